// File: rtl/master_bridge_fifo_wr_ctrl.sv
// Write-side controller of an async FIFO: binary/Gray write pointer, read-pointer sync, full/level flags.
// Optional sticky overflow detect enabled by defining MASTER_BRIDGE_WR_OVF_DET_EN.
module master_bridge_fifo_wr_ctrl #(
    parameter int ADDR_WIDTH   = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  W_CLK,
    input  logic                  W_RST,
    input  logic                  wr_inc,
    input  logic [ADDR_WIDTH:0]   gray_rd_ptr,
    input  logic                  ovf_clr,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_en,
    output logic [ADDR_WIDTH:0]   gray_wr_ptr,
    output logic                  wr_full,
    output logic                  wr_almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  wr_overflow
);

    localparam int AW = ADDR_WIDTH;
    localparam logic [AW:0] AFULL_LVL = AFULL_THRESH[AW:0];

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [AW:0] wbin_q, wbin_d;
    logic [AW:0] gray_q, gray_d;
    logic [AW:0] level_q, level_d;
    logic        full_q, full_d;
    logic        afull_q, afull_d;
    logic [AW:0] sync_q [SYNC_STAGES];
    logic [AW:0] sync_d [SYNC_STAGES];
    logic [AW:0] rq;
    logic [AW:0] rbin;
    logic [AW:0] rq_full;

    assign wr_en = wr_inc & ~full_q & ~W_RST;
    assign rq    = sync_q[SYNC_STAGES-1];
    assign rbin  = gray2bin(rq);

    // Full when the write pointer has lapped the synced read pointer exactly once.
    assign rq_full = {~rq[AW], ~rq[AW-1], rq[AW-2:0]};

    always_comb begin
        wbin_d     = wbin_q + {{AW{1'b0}}, wr_en};
        gray_d     = wbin_d ^ (wbin_d >> 1);
        full_d     = (gray_d == rq_full);
        level_d    = wbin_d - rbin;
        afull_d    = (level_d >= AFULL_LVL);
        sync_d[0]  = gray_rd_ptr;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge W_CLK) begin
        if (W_RST) begin
            wbin_q  <= '0;
            gray_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            wbin_q  <= wbin_d;
            gray_q  <= gray_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign wr_addr        = wbin_q[AW-1:0];
    assign gray_wr_ptr    = gray_q;
    assign wr_full        = full_q;
    assign wr_almost_full = afull_q;
    assign wr_level       = level_q;

`ifdef MASTER_BRIDGE_WR_OVF_DET_EN
    logic ovf_q, ovf_d;

    // A dropped write takes priority over a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (wr_inc && full_q) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge W_CLK) begin
        if (W_RST) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign wr_overflow = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign wr_overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_master_bridge_fifo_wr_ctrl.sv
// Scoreboard bench for master_bridge_fifo_wr_ctrl (ADDR_WIDTH=3, SYNC_STAGES=2, AFULL_THRESH=6).
module tb_master_bridge_fifo_wr_ctrl;

`ifdef MASTER_BRIDGE_WR_OVF_DET_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic       W_CLK = 1'b0;
    logic       W_RST = 1'b1;
    logic       wr_inc = 1'b0;
    logic [3:0] gray_rd_ptr = '0;
    logic       ovf_clr = 1'b0;
    logic [2:0] wr_addr;
    logic       wr_en;
    logic [3:0] gray_wr_ptr;
    logic       wr_full;
    logic       wr_almost_full;
    logic [3:0] wr_level;
    logic       wr_overflow;

    master_bridge_fifo_wr_ctrl #(
        .ADDR_WIDTH  (3),
        .SYNC_STAGES (2),
        .AFULL_THRESH(6)
    ) dut (
        .W_CLK         (W_CLK),
        .W_RST         (W_RST),
        .wr_inc        (wr_inc),
        .gray_rd_ptr   (gray_rd_ptr),
        .ovf_clr       (ovf_clr),
        .wr_addr       (wr_addr),
        .wr_en         (wr_en),
        .gray_wr_ptr   (gray_wr_ptr),
        .wr_full       (wr_full),
        .wr_almost_full(wr_almost_full),
        .wr_level      (wr_level),
        .wr_overflow   (wr_overflow)
    );

    always #5 W_CLK = ~W_CLK;

    typedef struct {
        logic [2:0] addr;
        logic [3:0] gray;
        logic [3:0] lvl;
        logic       full;
        logic       af;
        logic       ovf;
        logic       en;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs settle after the posedge; inputs of that cycle are still applied.
    always @(negedge W_CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, ".wr_addr"}, {1'b0, wr_addr}, {1'b0, e.addr});
            chk({e.tag, ".gray_wr_ptr"}, gray_wr_ptr, e.gray);
            chk({e.tag, ".wr_level"}, wr_level, e.lvl);
            chk({e.tag, ".wr_full"}, {3'b0, wr_full}, {3'b0, e.full});
            chk({e.tag, ".wr_almost_full"}, {3'b0, wr_almost_full}, {3'b0, e.af});
            chk({e.tag, ".wr_overflow"}, {3'b0, wr_overflow}, {3'b0, e.ovf});
            chk({e.tag, ".wr_en"}, {3'b0, wr_en}, {3'b0, e.en});
        end
    end

    // Drive one cycle and queue the state expected after the following edge.
    task automatic cyc(input logic rst, input logic inc, input logic clr,
                       input logic [3:0] rd_bin, input logic [3:0] wbin,
                       input logic [3:0] lvl, input logic full, input logic af,
                       input logic ovf, input logic en, input string tag);
        exp_t e;
        @(negedge W_CLK);
        #1;
        W_RST       = rst;
        wr_inc      = inc;
        ovf_clr     = clr;
        gray_rd_ptr = b2g(rd_bin);
        e.addr = wbin[2:0];
        e.gray = b2g(wbin);
        e.lvl  = lvl;
        e.full = full;
        e.af   = af;
        e.ovf  = ovf;
        e.en   = en;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst0");
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, "rst1");

        // Fill from empty: almost-full from the 6th write, full on the 8th.
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 1, 0, 0, 4'(k), 4'(k), (k == 8), (k >= 6), 0, (k < 8), "fill");
        end

        // Writes while full are dropped.
        cyc(0, 1, 0, 0, 8, 8, 1, 1, OVF_ON, 0, "drop1");
        cyc(0, 1, 0, 0, 8, 8, 1, 1, OVF_ON, 0, "drop2");
        cyc(0, 0, 1, 0, 8, 8, 1, 1, 0, 0, "ovfclr");

        // Read pointer 0->1 reaches the flags three edges later.
        cyc(0, 0, 0, 1, 8, 8, 1, 1, 0, 0, "rd1_e1");
        cyc(0, 0, 0, 1, 8, 8, 1, 1, 0, 0, "rd1_e2");
        cyc(0, 0, 0, 1, 8, 7, 0, 1, 0, 0, "rd1_e3");

        // Read pointer to 6: level 2 after sync latency.
        cyc(0, 0, 0, 6, 8, 7, 0, 1, 0, 0, "rd6_e1");
        cyc(0, 0, 0, 6, 8, 7, 0, 1, 0, 0, "rd6_e2");
        cyc(0, 0, 0, 6, 8, 2, 0, 0, 0, 0, "rd6_e3");

        // Streaming write+read across several pointer wraps.
        for (int j = 0; j < 40; j++) begin
            cyc(0, 1, 0, 4'(7 + j), 4'(9 + j), (j == 0) ? 4'd3 : 4'd4,
                0, 0, 0, 1, "wrap");
        end

        // Reset from level 5 with a pending write.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst2");
        for (int k = 1; k <= 5; k++) begin
            cyc(0, 1, 0, 0, 4'(k), 4'(k), 0, 0, 0, 1, "lvl5");
        end
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, "rst_mid");
        cyc(0, 1, 0, 0, 1, 1, 0, 0, 0, 1, "post_rst_wr");
        cyc(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, "idle");

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge W_CLK);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/master_bridge_fifo_wr_ctrl.md
MASTER_BRIDGE_FIFO_WR_CTRL -- requirements
Module: master_bridge_fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, log2 FIFO depth; legal range 2..8; depth = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of W_CLK flops synchronising gray_rd_ptr; legal range 2..4.
REQ-003 SHALL have parameter AFULL_THRESH, default 6, fill level at or above which wr_almost_full asserts; legal range 1..2**ADDR_WIDTH.
REQ-004 W_CLK  input  1  write-domain clock; all state on rising edge.
REQ-005 W_RST  input  1  synchronous, active-high reset.
REQ-006 wr_inc  input  1  write request for the current cycle.
REQ-007 gray_rd_ptr  input  ADDR_WIDTH+1  Gray-coded read pointer from read domain, asynchronous to W_CLK.
REQ-008 wr_addr  output  ADDR_WIDTH  RAM write address, low bits of binary write pointer.
REQ-009 wr_en  output  1  RAM write enable, combinational: wr_inc AND NOT wr_full.
REQ-010 gray_wr_ptr  output  ADDR_WIDTH+1  registered Gray-coded write pointer for the read domain.
REQ-011 wr_full  output  1  registered full flag.
REQ-012 wr_almost_full  output  1  registered, level >= AFULL_THRESH.
REQ-013 wr_level  output  ADDR_WIDTH+1  registered fill level, 0..2**ADDR_WIDTH.
REQ-014 wr_overflow  output  1  sticky dropped-write flag (see Configuration).
REQ-015 ovf_clr  input  1  clears wr_overflow (see Configuration).

Function
REQ-016 Binary write pointer wbin (ADDR_WIDTH+1 bits) SHALL increment by 1 modulo 2**(ADDR_WIDTH+1) on each edge with wr_en=1; otherwise hold.
REQ-017 gray_wr_ptr SHALL be registered as wbin_next XOR (wbin_next >> 1), updating on the same edge as wbin.
REQ-018 gray_rd_ptr SHALL pass through a SYNC_STAGES-deep flop chain; last stage = rq; rq SHALL be converted Gray-to-binary (rbin) combinationally.
REQ-019 wr_full SHALL register (gray(wbin_next) == {~rq[MSB], ~rq[MSB-1], rq[MSB-2:0]}).
REQ-020 wr_level SHALL register (wbin_next - rbin) modulo 2**(ADDR_WIDTH+1); wr_almost_full SHALL register (that value >= AFULL_THRESH).
REQ-021 Write accepted at edge k: wr_addr, gray_wr_ptr, wr_level, wr_full reflect it after edge k (latency 1).
REQ-022 Read-pointer change at gray_rd_ptr SHALL appear in wr_level/wr_full after SYNC_STAGES+1 edges; flags are conservative (never report less full than true).
REQ-023 wr_inc while wr_full=1: wr_en=0, pointer unchanged, request dropped.
REQ-024 Write accepted in same cycle the synced read pointer advances: level SHALL remain unchanged and full SHALL not assert.
REQ-025 Pointer wrap 2**(ADDR_WIDTH+1)-1 -> 0 SHALL be seamless; level and full correct across wrap.

Reset
REQ-026 W_RST=1 at an edge SHALL clear wbin, gray_wr_ptr, all sync stages, wr_full, wr_almost_full, wr_level, wr_overflow to 0; wr_addr=0.
REQ-027 Reset mid-operation SHALL take priority over wr_inc; wr_en SHALL be 0 while W_RST=1.

Configuration
REQ-028 Macro MASTER_BRIDGE_WR_OVF_DET_EN defined: wr_overflow SHALL set on edge where wr_inc=1 and wr_full=1, hold until ovf_clr=1 or reset; set wins over simultaneous ovf_clr.
REQ-029 Macro undefined: wr_overflow SHALL be constant 0, ovf_clr ignored, no overflow flop synthesised.

Verification (ADDR_WIDTH=3, SYNC_STAGES=2, AFULL_THRESH=6)
REQ-030 Reset, gray_rd_ptr=0, wr_inc=1 for 8 cycles -> wr_addr 0..7, wr_level 1..8, wr_almost_full after 6th write, wr_full after 8th, gray_wr_ptr=4'b1100.
REQ-031 Full, wr_inc=1 two more cycles -> wr_en=0, wr_addr stays 0, wr_overflow=1 (macro on) / 0 (macro off); ovf_clr pulse -> 0.
REQ-032 Full, gray_rd_ptr 0->1 -> wr_full deasserts and wr_level=7 exactly 3 edges later.
REQ-033 Continuous write+read (rd ptr tracking 2 behind) for 40 cycles -> pointers wrap past 15, wr_level stable, no false full.
REQ-034 Level 5, W_RST=1 with wr_inc=1 -> all outputs 0 next edge, first post-reset write uses wr_addr=0.
